regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised register file for the pipelined core, replacing the fixed 8x16 single-cycle register file. It provides two combinational read ports and one write port, with optional write-to-read bypass. A per-register busy scoreboard tracks in-flight destinations so issue logic stalls on RAW and WAW hazards. Register 0 is optionally hardwired to zero.

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 8, number of architectural registers (power of 2, >=2)
ADDR_W, $clog2(NUM_REGS), register index width (derived; do not override)
ZERO_REG, 1, 1: register 0 reads 0, ignores writes, is never busy
BYPASS, 1, 1: a same-cycle writeback is visible on read ports and clears busy combinationally

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
rd_addr1  in  ADDR_W  read port 1 index (rB field)
rd_addr2  in  ADDR_W  read port 2 index (rC or rA, selected upstream)
rd_data1  out  DATA_W  read port 1 data, combinational
rd_data2  out  DATA_W  read port 2 data, combinational
use1  in  1  issuing instruction consumes rd_addr1
use2  in  1  issuing instruction consumes rd_addr2
issue_en  in  1  instruction requests issue
issue_wr  in  1  issuing instruction writes a destination
issue_dst  in  ADDR_W  destination index of issuing instruction
stall  out  1  issue refused this cycle, combinational
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback index
wr_data  in  DATA_W  writeback data
busy  out  NUM_REGS  scoreboard vector, registered
wb_err  out  1  sticky: writeback to a non-busy register, registered

Behaviour:
- Reset (async, rst=1): all registers 0, busy all 0, wb_err 0; rd_data* therefore read 0. Deassertion is synchronous to clk; reset mid-operation discards all pending busy state.
- Read: rd_dataN = reg[rd_addrN]. With BYPASS=1 and wr_en && wr_addr==rd_addrN (and not the zero register), rd_dataN = wr_data. With ZERO_REG=1 and rd_addrN==0, rd_dataN = 0 always.
- Write: at posedge, if wr_en, reg[wr_addr] <= wr_data, except register 0 when ZERO_REG=1.
- Effective busy eb[i] = busy[i] & ~(BYPASS & wr_en & wr_addr==i). With ZERO_REG=1, eb[0] = 0.
- stall = issue_en & ((use1 & eb[rd_addr1]) | (use2 & eb[rd_addr2]) | (issue_wr & eb[issue_dst])). This covers RAW on both sources and WAW on the destination.
- Accepted issue = issue_en & ~stall.
- Busy update at posedge, per register i:
  - Clear when wr_en & wr_addr==i.
  - Set when accepted issue & issue_wr & issue_dst==i.
  - Set has priority over clear for the same i (new in-flight write). Clear on one index and set on another occur independently.
  - Register 0 is never set when ZERO_REG=1.
- BYPASS=0: eb = busy; writeback data is visible the cycle after the write, and a stall caused by a register persists for exactly the cycle of its writeback.
- wb_err: set at posedge when wr_en & ~busy[wr_addr] & ~(ZERO_REG & wr_addr==0). Cleared only by rst. The write is still performed.
- No state machine beyond the scoreboard. Latency: read 0 cycles (combinational); write and busy updates 1 cycle.

Test Plan:
- Reset: load reg3=16'h1234, pulse rst mid-cycle -> rd_data1 with rd_addr1=3 reads 0 immediately; busy=8'h00; wb_err=0.
- Zero reg: wr_en, wr_addr=0, wr_data=16'hFFFF, then issue_dst=0 -> rd_data=0; busy[0]=0; stall=0; wb_err=0.
- RAW stall: issue_wr dst=5 accepted -> busy=8'h20. Next cycle issue with use1, rd_addr1=5 -> stall=1. Writeback wr_addr=5, data 16'hBEEF -> same cycle stall=0 and rd_data1=16'hBEEF (BYPASS=1); busy[5]=0 after the edge.
- Simultaneous set/clear: busy[2]=1; same cycle wr_en addr=2 and accepted issue dst=2 -> busy[2]=1 after the edge; reg2 holds the written data.
- WAW and error: busy[4]=1, issue dst=4 with no writeback -> stall=1, busy unchanged. wr_en addr=6 with busy[6]=0 -> wb_err=1 and stays 1 until rst.
- BYPASS=0 and NUM_REGS=32, DATA_W=32 build: write reg31=32'hCAFEF00D -> rd_data shows the old value that cycle and the new value the next cycle; a stall on reg31 holds through its writeback cycle.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised register file with busy scoreboard and write-to-read bypass
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    input  logic                use1,
    input  logic                use2,
    input  logic                issue_en,
    input  logic                issue_wr,
    input  logic [ADDR_W-1:0]   issue_dst,
    output logic                stall,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0] busy,
    output logic                wb_err
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] eb;
    logic                accept;
    logic                wr_zero;

    assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);

    // A writeback landing this cycle releases its register early when bypassing
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            eb[i] = busy[i] & ~((BYPASS != 0) & wr_en & (wr_addr == ADDR_W'(i)));
        end
        if (ZERO_REG != 0) begin
            eb[0] = 1'b0;
        end
    end

    always_comb begin
        rd_data1 = regs[rd_addr1];
        if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end
    end

    always_comb begin
        rd_data2 = regs[rd_addr2];
        if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_data2 = '0;
        end
    end

    assign stall  = issue_en & ((use1 & eb[rd_addr1]) | (use2 & eb[rd_addr2]) | (issue_wr & eb[issue_dst]));
    assign accept = issue_en & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && !wr_zero) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Set beats clear on the same index: a newly issued writer owns the register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (accept && issue_wr && (issue_dst == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                    busy[i] <= 1'b1;
                end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else if (wr_en && !busy[wr_addr] && !wr_zero) begin
            wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for an 8x16 bypassing and a 32x32 non-bypassing build
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  a1, a2, dst, wa;
    logic        u1, u2, ie, iw, we;
    logic [31:0] wd;

    logic [15:0] ra1, ra2;
    logic        sa, ea;
    logic [7:0]  ba;
    logic [31:0] rb1, rb2, bb;
    logic        sb, eb_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          k;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] bz;
        logic        st;
        logic        er;
    } exp_t;
    exp_t exq[$];

    logic [31:0] m_reg  [2][32];
    logic        m_busy [2][32];
    logic        m_err  [2];

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(16), .NUM_REGS(8), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr1(a1[2:0]), .rd_addr2(a2[2:0]), .rd_data1(ra1), .rd_data2(ra2),
        .use1(u1), .use2(u2), .issue_en(ie), .issue_wr(iw), .issue_dst(dst[2:0]), .stall(sa),
        .wr_en(we), .wr_addr(wa[2:0]), .wr_data(wd[15:0]), .busy(ba), .wb_err(ea)
    );

    regfile_scoreboard #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr1(a1), .rd_addr2(a2), .rd_data1(rb1), .rd_data2(rb2),
        .use1(u1), .use2(u2), .issue_en(ie), .issue_wr(iw), .issue_dst(dst), .stall(sb),
        .wr_en(we), .wr_addr(wa), .wr_data(wd), .busy(bb), .wb_err(eb_b)
    );

    // Reference model: instance 0 is 8x16 with bypass, instance 1 is 32x32 without
    function automatic int nr(int k);
        return (k == 0) ? 8 : 32;
    endfunction

    function automatic int ad(int k, logic [4:0] a);
        return (k == 0) ? int'(a[2:0]) : int'(a);
    endfunction

    function automatic logic [31:0] dm(int k, logic [31:0] d);
        return (k == 0) ? {16'h0, d[15:0]} : d;
    endfunction

    function automatic logic m_eb(int k, int i);
        if (i == 0) return 1'b0;
        return m_busy[k][i] && !(k == 0 && we && ad(k, wa) == i);
    endfunction

    function automatic logic [31:0] m_rd(int k, int a);
        if (a == 0) return 32'h0;
        if (k == 0 && we && ad(k, wa) == a) return dm(k, wd);
        return m_reg[k][a];
    endfunction

    function automatic logic m_stall(int k);
        return ie && ((u1 && m_eb(k, ad(k, a1))) || (u2 && m_eb(k, ad(k, a2))) || (iw && m_eb(k, ad(k, dst))));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 1'b0;
            for (int i = 0; i < 32; i++) begin
                m_reg[k][i]  = 32'h0;
                m_busy[k][i] = 1'b0;
            end
        end
    endtask

    task automatic model_edge(int k);
        logic st;
        int   w, d;
        st = m_stall(k);
        w  = ad(k, wa);
        d  = ad(k, dst);
        if (we && w != 0) begin
            if (!m_busy[k][w]) m_err[k] = 1'b1;
            m_reg[k][w]  = dm(k, wd);
            m_busy[k][w] = 1'b0;
        end
        if (ie && !st && iw && d != 0) m_busy[k][d] = 1'b1;
    endtask

    task automatic push_exp();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.k  = k;
            e.r1 = m_rd(k, ad(k, a1));
            e.r2 = m_rd(k, ad(k, a2));
            e.st = m_stall(k);
            e.er = m_err[k];
            e.bz = 32'h0;
            for (int i = 0; i < nr(k); i++) e.bz[i] = m_busy[k][i];
            exq.push_back(e);
        end
    endtask

    task automatic cyc(input logic r, input logic i_e, input logic i_w, input logic [4:0] d,
                       input logic s1, input logic [4:0] r1, input logic s2, input logic [4:0] r2,
                       input logic w_e, input logic [4:0] w_a, input logic [31:0] w_d);
        rst = r; ie = i_e; iw = i_w; dst = d; u1 = s1; a1 = r1; u2 = s2; a2 = r2;
        we = w_e; wa = w_a; wd = w_d;
        if (r) model_reset();
        push_exp();
        @(negedge clk);
        @(posedge clk);
        if (!rst) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
    endtask

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst%0d] t=%0t got=%h expected=%h", name, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (exq.size() > 0) begin
            exp_t e;
            e = exq.pop_front();
            if (e.k == 0) begin
                check("rd_data1", 0, {16'h0, ra1}, e.r1);
                check("rd_data2", 0, {16'h0, ra2}, e.r2);
                check("stall",    0, {31'h0, sa},  {31'h0, e.st});
                check("busy",     0, {24'h0, ba},  e.bz);
                check("wb_err",   0, {31'h0, ea},  {31'h0, e.er});
            end else begin
                check("rd_data1", 1, rb1, e.r1);
                check("rd_data2", 1, rb2, e.r2);
                check("stall",    1, {31'h0, sb},   {31'h0, e.st});
                check("busy",     1, bb,            e.bz);
                check("wb_err",   1, {31'h0, eb_b}, {31'h0, e.er});
            end
        end
    end

    initial begin
        int bq[$];
        model_reset();
        //   rst ie iw dst u1 a1 u2 a2 we wa wd
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 3, 0, 3, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 3, 0, 0, 1, 3, 32'h0000_1234);
        cyc(0, 0, 0, 0, 0, 3, 0, 3, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 3, 0, 3, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        // register zero
        cyc(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 32'hFFFF_FFFF);
        cyc(0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // RAW with same-cycle writeback
        cyc(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 5, 0, 0, 1, 5, 32'h0000_BEEF);
        cyc(0, 0, 0, 0, 1, 5, 0, 5, 0, 0, 0);
        // simultaneous set and clear
        cyc(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 2, 0, 2, 0, 0, 1, 2, 32'h0000_5A5A);
        cyc(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        // WAW stall, then writeback error
        cyc(0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 6, 0, 0, 1, 6, 32'h0000_0066);
        cyc(0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // top register: stall holds through a non-bypassed writeback
        cyc(0, 1, 1, 31, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 31, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 31, 1, 31, 1, 31, 32'hCAFE_F00D);
        cyc(0, 1, 0, 0, 1, 31, 1, 31, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            logic [4:0] w;
            bq.delete();
            for (int i = 1; i < 32; i++) if (m_busy[1][i]) bq.push_back(i);
            w = 5'($urandom_range(0, 31));
            if (bq.size() > 0 && ($urandom % 4) != 0) w = 5'(bq[$urandom % bq.size()]);
            cyc((n == 200), ($urandom % 4) != 0, $urandom % 2, 5'($urandom), $urandom % 2, 5'($urandom),
                $urandom % 2, 5'($urandom), ($urandom % 3) != 0, w, $urandom);
        end
        checks++;
        if (exq.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d expected=0", exq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
